// File: rtl/hub75_capture.sv
// HUB75 receiver: samples the panel stream on clk, rebuilds bit-planes into 12-bit pixels
// and replays each completed row pair on a pixel write port.
module hub75_capture #(
  parameter int NUM_COLS  = 64,
  parameter int NUM_ROWS  = 64,
  parameter int BIT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hub_clk,
  input  logic        hub_r0,
  input  logic        hub_g0,
  input  logic        hub_b0,
  input  logic        hub_r1,
  input  logic        hub_g1,
  input  logic        hub_b1,
  input  logic        hub_latch,
  input  logic        hub_blank,
  input  logic [4:0]  hub_row,
  output logic        pix_valid,
  output logic [11:0] pix_addr,
  output logic [11:0] pix_data,
  output logic        frame_done,
  output logic        err_shift,
  output logic        err_overrun,
  output logic [15:0] on_cycles
);
  localparam int CI_W = $clog2(NUM_COLS);
  localparam int PL_W = $clog2(BIT_DEPTH + 1);
  localparam int IX_W = CI_W + 1;

  typedef enum logic {CAPTURE, STREAM} state_t;
  state_t state;

  logic            hclk_q, hclk_p, latch_q, latch_p, blank_q, blank_p;
  logic [5:0]      data_q;  // {r0,g0,b0,r1,g1,b1}
  logic [4:0]      row_q;
  logic            clk_rise, latch_rise, blank_rise;
  logic [CI_W:0]   col_cnt;
  logic [CI_W-1:0] col;
  logic [PL_W-1:0] plane, plane_nxt;
  logic [4:0]      last_row;
  logic [IX_W-1:0] idx;
  logic            fd_pend, row_change, count_ok, last_px;
  logic [15:0]     blank_cnt;
  logic [11:0]     acc_up [NUM_COLS];
  logic [11:0]     acc_dn [NUM_COLS];
  logic [5:0]      p0_buf [NUM_COLS];

  assign clk_rise   = hclk_q & ~hclk_p;
  assign latch_rise = latch_q & ~latch_p;
  assign blank_rise = blank_q & ~blank_p;
  assign col        = col_cnt[CI_W-1:0];
  assign count_ok   = (col_cnt == (CI_W+1)'(NUM_COLS));
  assign row_change = (row_q != last_row);
  // A new row restarts at plane 0, so the plane just latched becomes plane 0 of it.
  assign plane_nxt  = row_change ? PL_W'(1) : plane + PL_W'(1);
  assign last_px    = (idx == IX_W'(2*NUM_COLS-1));

  function automatic logic [11:0] set_bits(input logic [11:0] v, input logic [PL_W-1:0] p,
                                           input logic r, input logic g, input logic b);
    logic [11:0] w;
    w = v;
    for (int k = 0; k < BIT_DEPTH; k++) begin
      if (PL_W'(k) == p) begin
        w[2*BIT_DEPTH+k] = w[2*BIT_DEPTH+k] | r;
        w[BIT_DEPTH+k]   = w[BIT_DEPTH+k] | g;
        w[k]             = w[k] | b;
      end
    end
    return w;
  endfunction

  function automatic logic [11:0] clear_plane(input logic [11:0] v, input logic [PL_W-1:0] p);
    logic [11:0] w;
    w = v;
    for (int k = 0; k < BIT_DEPTH; k++) begin
      if (PL_W'(k) == p) begin
        w[2*BIT_DEPTH+k] = 1'b0;
        w[BIT_DEPTH+k]   = 1'b0;
        w[k]             = 1'b0;
      end
    end
    return w;
  endfunction

  // Keeps only the bits of plane p, moved down to plane 0.
  function automatic logic [11:0] keep_plane(input logic [11:0] v, input logic [PL_W-1:0] p);
    logic [11:0] w;
    w = '0;
    for (int k = 0; k < BIT_DEPTH; k++) begin
      if (PL_W'(k) == p) begin
        w[2*BIT_DEPTH] = v[2*BIT_DEPTH+k];
        w[BIT_DEPTH]   = v[BIT_DEPTH+k];
        w[0]           = v[k];
      end
    end
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      hclk_q <= 1'b0; hclk_p <= 1'b0; latch_q <= 1'b0; latch_p <= 1'b0;
      blank_q <= 1'b1; blank_p <= 1'b1; data_q <= '0; row_q <= '0;
    end else begin
      hclk_q  <= hub_clk;   hclk_p  <= hclk_q;
      latch_q <= hub_latch; latch_p <= latch_q;
      blank_q <= hub_blank; blank_p <= blank_q;
      data_q  <= {hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1};
      row_q   <= hub_row;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blank_cnt <= '0;
      on_cycles <= '0;
    end else if (blank_rise) begin
      on_cycles <= blank_cnt;
      blank_cnt <= '0;
    end else if (!blank_q && blank_cnt != 16'hFFFF) begin
      blank_cnt <= blank_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CAPTURE; col_cnt <= '0; plane <= '0; last_row <= '0; idx <= '0;
      fd_pend <= 1'b0; pix_valid <= 1'b0; pix_addr <= '0; pix_data <= '0;
      frame_done <= 1'b0; err_shift <= 1'b0; err_overrun <= 1'b0;
      for (int i = 0; i < NUM_COLS; i++) begin
        acc_up[i] <= '0; acc_dn[i] <= '0; p0_buf[i] <= '0;
      end
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= fd_pend;
      fd_pend    <= 1'b0;
      case (state)
        CAPTURE: begin
          if (latch_rise) begin
            col_cnt <= '0;
            if (!count_ok) begin
              err_shift <= 1'b1;
              for (int i = 0; i < NUM_COLS; i++) begin
                acc_up[i] <= clear_plane(acc_up[i], plane);
                acc_dn[i] <= clear_plane(acc_dn[i], plane);
              end
            end else begin
              if (row_change) begin
                last_row <= row_q;
                for (int i = 0; i < NUM_COLS; i++) begin
                  acc_up[i] <= keep_plane(acc_up[i], plane);
                  acc_dn[i] <= keep_plane(acc_dn[i], plane);
                end
              end
              plane <= plane_nxt;
              if (plane_nxt == PL_W'(BIT_DEPTH)) begin
                state <= STREAM;
                idx   <= '0;
                for (int i = 0; i < NUM_COLS; i++) p0_buf[i] <= '0;
              end
            end
          end else if (clk_rise && !count_ok) begin
            acc_up[col] <= set_bits(acc_up[col], plane, data_q[5], data_q[4], data_q[3]);
            acc_dn[col] <= set_bits(acc_dn[col], plane, data_q[2], data_q[1], data_q[0]);
            col_cnt     <= col_cnt + 1'b1;
          end
        end
        STREAM: begin
          pix_valid <= 1'b1;
          pix_addr  <= {idx[CI_W], last_row, idx[CI_W-1:0]};
          pix_data  <= idx[CI_W] ? acc_dn[idx[CI_W-1:0]] : acc_up[idx[CI_W-1:0]];
          idx       <= idx + 1'b1;
          if (last_px) begin
            state   <= CAPTURE;
            plane   <= '0;
            fd_pend <= (last_row == 5'(NUM_ROWS/2-1));
            for (int i = 0; i < NUM_COLS; i++) begin
              acc_up[i] <= set_bits('0, '0, p0_buf[i][5], p0_buf[i][4], p0_buf[i][3]);
              acc_dn[i] <= set_bits('0, '0, p0_buf[i][2], p0_buf[i][1], p0_buf[i][0]);
            end
          end
          if (latch_rise) begin
            err_overrun <= 1'b1;
            col_cnt     <= '0;
          end else if (clk_rise && !count_ok) begin
            // Early plane-0 shifts of the next row; a shift on the exit cycle lands directly.
            p0_buf[col] <= data_q;
            col_cnt     <= col_cnt + 1'b1;
            if (last_px) begin
              acc_up[col] <= set_bits('0, '0, data_q[5], data_q[4], data_q[3]);
              acc_dn[col] <= set_bits('0, '0, data_q[2], data_q[1], data_q[0]);
            end
          end
        end
        default: state <= CAPTURE;
      endcase
    end
  end
endmodule

// File: tb/tb_hub75_capture.sv
// Bench for hub75_capture: drives HUB75 rows built from random images and scores the pixel port.
module tb_hub75_capture;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hub_clk = 1'b0, hub_latch = 1'b0, hub_blank = 1'b1;
  logic        hub_r0 = 1'b0, hub_g0 = 1'b0, hub_b0 = 1'b0;
  logic        hub_r1 = 1'b0, hub_g1 = 1'b0, hub_b1 = 1'b0;
  logic [4:0]  hub_row = '0;
  logic        pix_valid, frame_done, err_shift, err_overrun;
  logic [11:0] pix_addr, pix_data;
  logic [15:0] on_cycles;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;
  logic        prev_valid = 1'b0;
  logic [11:0] prev_addr = '0;
  logic [23:0] exp_q[$];
  logic [11:0] img_up [64];
  logic [11:0] img_dn [64];
  int blank_ns [4] = '{64, 128, 256, 512};

  hub75_capture dut (
    .clk(clk), .reset(reset), .hub_clk(hub_clk),
    .hub_r0(hub_r0), .hub_g0(hub_g0), .hub_b0(hub_b0),
    .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
    .hub_latch(hub_latch), .hub_blank(hub_blank), .hub_row(hub_row),
    .pix_valid(pix_valid), .pix_addr(pix_addr), .pix_data(pix_data),
    .frame_done(frame_done), .err_shift(err_shift), .err_overrun(err_overrun),
    .on_cycles(on_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_image();
    for (int c = 0; c < 64; c++) begin
      img_up[c] = 12'($urandom);
      img_dn[c] = 12'($urandom);
    end
  endtask

  // A completed row pair appears as 64 upper pixels then 64 lower pixels.
  task automatic push_row(input int row);
    for (int c = 0; c < 64; c++) exp_q.push_back({12'(row*64 + c), img_up[c]});
    for (int c = 0; c < 64; c++) exp_q.push_back({12'(2048 + row*64 + c), img_dn[c]});
  endtask

  task automatic latch_pulse(input int row);
    hub_row = 5'(row);
    hub_latch = 1'b1;
    cyc(2);
    hub_latch = 1'b0;
    cyc(2);
  endtask

  task automatic send_plane(input int row, input int p, input int ncols, input int blank_n);
    hub_row = 5'(row);
    for (int c = 0; c < ncols; c++) begin
      hub_r0 = img_up[c][8+p]; hub_g0 = img_up[c][4+p]; hub_b0 = img_up[c][p];
      hub_r1 = img_dn[c][8+p]; hub_g1 = img_dn[c][4+p]; hub_b1 = img_dn[c][p];
      cyc(2);
      hub_clk = 1'b1;
      cyc(2);
      hub_clk = 1'b0;
    end
    latch_pulse(row);
    if (blank_n > 0) begin
      hub_blank = 1'b0;
      cyc(blank_n);
      hub_blank = 1'b1;
      cyc(3);
      chk("on_cycles", 32'(on_cycles), 32'(blank_n));
    end
  endtask

  task automatic send_row(input int row);
    for (int p = 0; p < 4; p++) send_plane(row, p, 64, 0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_done) begin
        fd_count++;
        chk("frame_done_pos", {prev_valid, prev_addr}, {1'b1, 12'd4095});
      end
      if (pix_valid) begin
        chk("pix_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("pix", {pix_addr, pix_data}, exp_q.pop_front());
      end
    end
    prev_valid = pix_valid;
    prev_addr  = pix_addr;
  end

  initial begin
    cyc(4);
    chk("rst_valid", pix_valid, 0);
    chk("rst_addr", pix_addr, 0);
    chk("rst_data", pix_data, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_errs", {err_shift, err_overrun}, 0);
    chk("rst_on", on_cycles, 0);
    reset = 1'b0;
    cyc(4);

    // Row 0 with column-index pattern, plus blank timing per plane.
    for (int c = 0; c < 64; c++) begin
      logic [3:0] n;
      n = 4'(c);
      img_up[c] = {n, n, n};
      img_dn[c] = {n, n, n};
    end
    push_row(0);
    for (int p = 0; p < 4; p++) send_plane(0, p, 64, blank_ns[p]);
    cyc(150);
    chk("row0_drained", 32'(exp_q.size()), 0);
    chk("row0_errs", {err_shift, err_overrun}, 0);

    // Full frame, rows back to back so the next plane 0 overlaps each stream.
    for (int r = 0; r < 32; r++) begin
      rand_image();
      push_row(r);
      send_row(r);
    end
    cyc(150);
    chk("frame_drained", 32'(exp_q.size()), 0);
    chk("frame_done_count", 32'(fd_count), 1);
    chk("frame_errs", {err_shift, err_overrun}, 0);

    // Short plane, then a correct retransmission.
    rand_image();
    send_plane(5, 0, 63, 0);
    chk("err_shift", err_shift, 1);
    push_row(5);
    send_row(5);
    cyc(150);
    chk("short_drained", 32'(exp_q.size()), 0);

    // Latch injected during streaming.
    rand_image();
    push_row(7);
    send_row(7);
    cyc(8);
    latch_pulse(7);
    cyc(3);
    chk("err_overrun", err_overrun, 1);
    cyc(150);
    chk("overrun_drained", 32'(exp_q.size()), 0);

    reset = 1'b1;
    cyc(2);
    chk("rst_clears_errs", {err_shift, err_overrun}, 0);
    reset = 1'b0;
    cyc(3);

    // Row abandoned after two planes, next row intact.
    rand_image();
    send_plane(3, 0, 64, 0);
    send_plane(3, 1, 64, 0);
    rand_image();
    push_row(4);
    send_row(4);
    cyc(150);
    chk("switch_drained", 32'(exp_q.size()), 0);
    chk("switch_errs", {err_shift, err_overrun}, 0);

    // Reset during streaming.
    rand_image();
    push_row(9);
    send_row(9);
    cyc(20);
    reset = 1'b1;
    cyc(1);
    chk("midrst_valid", pix_valid, 0);
    chk("midrst_addr_data", {pix_addr, pix_data}, 0);
    chk("midrst_flags", {frame_done, err_shift, err_overrun}, 0);
    chk("midrst_on", on_cycles, 0);
    exp_q.delete();
    reset = 1'b0;
    cyc(5);
    chk("final_frame_done_count", 32'(fd_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
